multi_enq_shift_queue: RTL and testbench
========================================

// Module: multi_enq_shift_queue
// PURPOSE
//  Collapsing (shift) queue for the LSQ and issue queue. Accepts up to N_ENQ entries per cycle in program order.
//  Removes any one selected entry per cycle and any set of squashed entries per cycle.
//  Survivors compact toward index 0 with age order kept. Entry 0 is always the oldest.
// PARAMETERS
//  N_ENTRIES    8   queue depth (>=2)
//  ENTRY_WIDTH  81  payload bits per entry
//  N_ENQ        2   enqueue lanes per cycle (1..N_ENTRIES)
//  CTR_WIDTH    derived, $clog2(N_ENTRIES)+1; width of the occupancy count
// PORTS
//  clk             in   1                    clock
//  rst             in   1                    synchronous reset, active-high
//  enq_ready       out  N_ENQ                lane k may enqueue this cycle
//  enq_valid       in   N_ENQ                lane k valid; must be packed (valid[k] -> valid[k-1])
//  enq_data        in   N_ENQ x ENTRY_WIDTH  lane payloads; lane 0 is oldest
//  deq_ready       in   1                    consumer takes the selected entry
//  deq_sel_onehot  in   N_ENTRIES            one-hot or all-0 dequeue select
//  deq_valid       out  1                    selected entry exists and is valid
//  deq_data        out  ENTRY_WIDTH          payload of the selected entry
//  flush_valid     in   1                    squash request
//  flush_mask      in   N_ENTRIES            entries to squash when flush_valid
//  wr_en           in   N_ENTRIES            per-entry in-place payload update
//  wr_data         in   N_ENTRIES x ENTRY_WIDTH  update payloads
//  entry_valid     out  N_ENTRIES            thermometer valid vector, bits [0..count-1] set
//  entry_douts     out  N_ENTRIES x ENTRY_WIDTH  registered payloads
//  count           out  CTR_WIDTH            occupied entries, 0..N_ENTRIES
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): count=0, all payload regs=0, entry_valid=0, enq_ready=all 1, deq_valid=0.
//  Reset takes priority over every same-cycle enq, deq, flush and write.
//  deq_valid = |(deq_sel_onehot & entry_valid). It is combinational, as is deq_data (mux of the selected entry).
//  deq = deq_ready & deq_valid.
//  Removal mask rm = (deq ? deq_sel_onehot : 0) | (flush_valid ? flush_mask & entry_valid : 0).
//  Mask bits on invalid entries are ignored. Deq and flush of the same entry count once.
//  enq_ready[k] = !flush_valid && (count + k < N_ENTRIES).
//  enq_ready is based on current count only; there is no combinational path from deq to enq_ready.
//  Lane k is accepted iff enq_valid[k] & enq_ready[k]. n_acc = number of accepted lanes.
//  Same-cycle in-place writes: wr_en[i] on a valid, non-removed entry i replaces its payload before compaction, so the new value moves with the entry.
//  wr_en on an invalid or removed entry is dropped.
//  Compaction: survivor i moves to i - popcount(rm[i-1:0]). Relative order of survivors is preserved.
//  Appended lane j lands at (count - popcount(rm)) + j.
//  next count = count - popcount(rm) + n_acc. Latency is 1 cycle for every update. The count can never overflow.
//  Vacated slots keep stale payload. Their entry_valid bit is 0, and consumers must qualify on entry_valid.
//  Empty (count=0): deq_valid=0 for any select, and flush has no effect.
//  Full (count=N): enq_ready=0 in the same cycle, even if a deq also occurs that cycle.
//  Assertions: deq_sel_onehot is $onehot0; enq_valid is packed; count <= N_ENTRIES; entry_valid is thermometer.
// STRUCTURE
//  multi_enq_shift_queue_pkg: CTR_WIDTH helper and a popcount function.
//  Sub-module shift_compact_map (N_ENTRIES): rm mask -> per-entry destination index and total removed (prefix popcount).
//  The top level holds the count register, the payload array, the next-state mux per slot, and the enq lane placement.
// TESTING (N_ENTRIES=8, N_ENQ=2, payload = entry id)
//  1. Reset, then enq lanes {A,B} valid for 4 cycles -> count 2,4,6,8; entry_douts[0..7] = A0,B0..A3,B3; enq_ready=00 at count 8.
//  2. Full queue, deq_sel=0b0000_0100 with deq_ready=1 -> deq_data=entry2 that cycle; next cycle count=7, entries 3..7 shifted down one slot, entry_valid=0x7F.
//  3. count=6, same cycle: deq_sel entry1, flush_mask=0b0011_0000, enq lanes {X,Y} -> enq_ready=00 (flush); next cycle count=3, order = e0,e2,e3.
//  4. count=5, deq_sel entry0, wr_en[3]=1 with Z, enq {X,Y} -> next cycle count=6; slot2 = Z; slots 4,5 = X,Y.
//  5. count=3, deq_sel entry5 (invalid), flush_mask=0xF0 -> deq_valid=0; count stays 3; data unchanged.
//  6. count=4, rst=1 with enq {X,Y} and a deq -> next cycle count=0, entry_valid=0, all payloads 0, enq_ready=11.

Source files
------------

// File: rtl/multi_enq_shift_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_enq_shift_queue_pkg
// Description : Shared sizing helpers for the collapsing shift queue.
//               ctr_width() gives the width of the occupancy count.
//               popcount() counts the set bits of a vector of up to
//               POP_MAX_W bits.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_enq_shift_queue_pkg;

  localparam int POP_MAX_W = 64;

  // The count must hold the value N itself, so it needs one more bit than
  // an index does.
  function automatic int ctr_width(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int popcount(input logic [POP_MAX_W-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      c += int'(v[i]);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_enq_shift_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_enq_shift_queue_if
// Description : Bundle of the enqueue, dequeue, flush, in-place-write and
//               status signals of the shift queue.
//               slave  : the queue (drives enq_ready, deq_valid/data,
//                        entry_valid, entry_douts, count)
//               master : the user of the queue (drives everything else)
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_enq_shift_queue_if
  import multi_enq_shift_queue_pkg::*;
#(
  parameter int N_ENTRIES   = 8,
  parameter int ENTRY_WIDTH = 81,
  parameter int N_ENQ       = 2,
  parameter int CTR_WIDTH   = ctr_width(N_ENTRIES)
);
  logic [N_ENQ-1:0]                        enq_ready;
  logic [N_ENQ-1:0]                        enq_valid;
  logic [N_ENQ-1:0][ENTRY_WIDTH-1:0]       enq_data;
  logic                                    deq_ready;
  logic [N_ENTRIES-1:0]                    deq_sel_onehot;
  logic                                    deq_valid;
  logic [ENTRY_WIDTH-1:0]                  deq_data;
  logic                                    flush_valid;
  logic [N_ENTRIES-1:0]                    flush_mask;
  logic [N_ENTRIES-1:0]                    wr_en;
  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]   wr_data;
  logic [N_ENTRIES-1:0]                    entry_valid;
  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]   entry_douts;
  logic [CTR_WIDTH-1:0]                    count;

  modport slave (
    output enq_ready, deq_valid, deq_data, entry_valid, entry_douts, count,
    input  enq_valid, enq_data, deq_ready, deq_sel_onehot,
           flush_valid, flush_mask, wr_en, wr_data
  );

  modport master (
    input  enq_ready, deq_valid, deq_data, entry_valid, entry_douts, count,
    output enq_valid, enq_data, deq_ready, deq_sel_onehot,
           flush_valid, flush_mask, wr_en, wr_data
  );

endinterface
`default_nettype wire

// File: rtl/multi_enq_shift_queue_shift_compact_map.sv
`default_nettype none
// ============================================================================
// Module      : shift_compact_map
// Description : Turns a removal mask into per-entry destination slots.
//               Entry i moves down by the number of removed entries below
//               it, which keeps survivors in age order.
// Ports       : rm        in  N_ENTRIES               removal mask
//               dest      out N_ENTRIES x IDX_W       destination slot
//               n_removed out CTR_WIDTH               popcount(rm)
// Revision    : 1.0 - initial release
// ============================================================================
module shift_compact_map
  import multi_enq_shift_queue_pkg::*;
#(
  parameter int N_ENTRIES = 8,
  parameter int CTR_WIDTH = ctr_width(N_ENTRIES),
  parameter int IDX_W     = $clog2(N_ENTRIES)
) (
  input  wire logic [N_ENTRIES-1:0]            rm,
  output logic      [N_ENTRIES-1:0][IDX_W-1:0] dest,
  output logic      [CTR_WIDTH-1:0]            n_removed
);

  logic [CTR_WIDTH-1:0] run;

  // Running prefix popcount: when entry i is visited, run holds
  // popcount(rm[i-1:0]).
  always_comb begin
    run  = '0;
    dest = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      dest[i] = IDX_W'(i) - run[IDX_W-1:0];
      run     = run + CTR_WIDTH'(rm[i]);
    end
    n_removed = run;
  end

endmodule
`default_nettype wire

// File: rtl/multi_enq_shift_queue.sv
`default_nettype none
// ============================================================================
// Module      : multi_enq_shift_queue
// Description : Collapsing shift queue. Up to N_ENQ in-order enqueues, one
//               selected dequeue and any set of flushes per cycle. Survivors
//               compact toward slot 0, so slot 0 always holds the oldest.
// Ports       : clk, rst (synchronous, active-high)
//               bus (slave modport of multi_enq_shift_queue_if)
// Revision    : 1.0 - initial release
// ============================================================================
module multi_enq_shift_queue
  import multi_enq_shift_queue_pkg::*;
#(
  parameter int N_ENTRIES   = 8,
  parameter int ENTRY_WIDTH = 81,
  parameter int N_ENQ       = 2
) (
  input wire logic               clk,
  input wire logic               rst,
  multi_enq_shift_queue_if.slave bus
);

  localparam int CTR_WIDTH = ctr_width(N_ENTRIES);
  localparam int IDX_W     = $clog2(N_ENTRIES);

  logic [CTR_WIDTH-1:0]                   count_q, count_d;
  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]  data_q, data_d;
  logic [N_ENTRIES-1:0]                   valid_vec;
  logic [N_ENTRIES-1:0]                   rm;
  logic                                   deq_fire;
  logic [N_ENTRIES-1:0][IDX_W-1:0]        dest;
  logic [CTR_WIDTH-1:0]                   n_removed;
  logic [CTR_WIDTH-1:0]                   n_acc;
  logic [CTR_WIDTH-1:0]                   base;
  logic [N_ENQ-1:0]                       ready;
  logic [N_ENQ-1:0]                       acc;
  logic [N_ENQ-1:0][CTR_WIDTH-1:0]        enq_slot;

  // Thermometer valid vector derived from the count alone.
  for (genvar i = 0; i < N_ENTRIES; i++) begin : g_valid
    assign valid_vec[i] = (CTR_WIDTH'(i) < count_q);
  end

  // Readiness looks only at the current count, never at this cycle's
  // dequeue, so there is no deq -> enq_ready combinational path.
  for (genvar k = 0; k < N_ENQ; k++) begin : g_lane
    assign ready[k]    = !bus.flush_valid &&
                         ((32'(count_q) + 32'(k)) < 32'(N_ENTRIES));
    assign acc[k]      = bus.enq_valid[k] & ready[k];
    assign enq_slot[k] = base + CTR_WIDTH'(k);
  end

  always_comb begin
    bus.deq_data = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (bus.deq_sel_onehot[i]) bus.deq_data = bus.deq_data | data_q[i];
    end
  end

  assign bus.deq_valid = |(bus.deq_sel_onehot & valid_vec);
  assign deq_fire      = bus.deq_ready & bus.deq_valid;
  // Deq and flush of the same entry merge into one removal bit.
  assign rm = (deq_fire ? bus.deq_sel_onehot : '0) |
              (bus.flush_valid ? (bus.flush_mask & valid_vec) : '0);

  shift_compact_map #(
    .N_ENTRIES (N_ENTRIES),
    .CTR_WIDTH (CTR_WIDTH),
    .IDX_W     (IDX_W)
  ) u_map (
    .rm        (rm),
    .dest      (dest),
    .n_removed (n_removed)
  );

  assign n_acc   = CTR_WIDTH'(popcount(POP_MAX_W'(acc)));
  assign base    = count_q - n_removed;
  assign count_d = base + n_acc;

  // Start from the current array so vacated slots keep stale payload, move
  // each survivor (with its same-cycle write applied) to its destination,
  // then place accepted lanes above the survivors.
  always_comb begin
    data_d = data_q;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (valid_vec[i] && !rm[i]) begin
        data_d[dest[i]] = bus.wr_en[i] ? bus.wr_data[i] : data_q[i];
      end
    end
    for (int j = 0; j < N_ENQ; j++) begin
      if (acc[j] && (32'(enq_slot[j]) < 32'(N_ENTRIES))) begin
        data_d[enq_slot[j][IDX_W-1:0]] = bus.enq_data[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      data_q  <= '0;
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign bus.enq_ready   = ready;
  assign bus.entry_valid = valid_vec;
  assign bus.entry_douts = data_q;
  assign bus.count       = count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(bus.deq_sel_onehot));
      assert (((bus.enq_valid >> 1) & ~bus.enq_valid) == '0);
      assert (32'(count_q) <= 32'(N_ENTRIES));
      assert ((valid_vec & (valid_vec + 1'b1)) == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_enq_shift_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_enq_shift_queue
// Description : Directed self-checking bench for multi_enq_shift_queue
//               (N_ENTRIES=8, N_ENQ=2, payload = entry id).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_enq_shift_queue;

  localparam int N  = 8;
  localparam int W  = 81;
  localparam int NE = 2;

  localparam logic [W-1:0] A0 = 81'h0A0, A1 = 81'h0A1, A2 = 81'h0A2, A3 = 81'h0A3;
  localparam logic [W-1:0] B0 = 81'h0B0, B1 = 81'h0B1, B2 = 81'h0B2, B3 = 81'h0B3;
  localparam logic [W-1:0] C0 = 81'h0C0, C1 = 81'h0C1;
  localparam logic [W-1:0] X  = 81'h1_0000_0000_0000_00E1;
  localparam logic [W-1:0] Y  = 81'h0E2, Z = 81'h0DD, WV = 81'h0F0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  multi_enq_shift_queue_if #(.N_ENTRIES(N), .ENTRY_WIDTH(W), .N_ENQ(NE)) q_if ();

  multi_enq_shift_queue #(.N_ENTRIES(N), .ENTRY_WIDTH(W), .N_ENQ(NE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (q_if.slave)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    q_if.enq_valid      = '0;
    q_if.enq_data       = '0;
    q_if.deq_ready      = 1'b0;
    q_if.deq_sel_onehot = '0;
    q_if.flush_valid    = 1'b0;
    q_if.flush_mask     = '0;
    q_if.wr_en          = '0;
    q_if.wr_data        = '0;
  endtask

  logic [W-1:0] exp_full [N];

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    chk("rst_count", q_if.count, 0);
    chk("rst_entry_valid", q_if.entry_valid, 0);
    chk("rst_enq_ready", q_if.enq_ready, 2'b11);
    q_if.deq_sel_onehot = 8'h01;
    #1;
    chk("empty_deq_valid", q_if.deq_valid, 0);
    q_if.deq_sel_onehot = '0;

    // Flush on an empty queue does nothing.
    q_if.flush_valid = 1'b1;
    q_if.flush_mask  = 8'hFF;
    tick();
    idle();
    chk("empty_flush_count", q_if.count, 0);

    // 1. Fill with {A,B} pairs.
    exp_full = '{A0, B0, A1, B1, A2, B2, A3, B3};
    for (int k = 0; k < 4; k++) begin
      q_if.enq_valid   = 2'b11;
      q_if.enq_data[0] = exp_full[2*k];
      q_if.enq_data[1] = exp_full[2*k+1];
      tick();
      chk($sformatf("fill_count_%0d", k), q_if.count, 2*(k+1));
    end
    idle();
    #1;
    chk("full_enq_ready", q_if.enq_ready, 2'b00);
    chk("full_entry_valid", q_if.entry_valid, 8'hFF);
    for (int i = 0; i < N; i++) chk($sformatf("full_dout_%0d", i), q_if.entry_douts[i], exp_full[i]);

    // 2. Dequeue entry 2 from a full queue.
    q_if.deq_sel_onehot = 8'h04;
    q_if.deq_ready      = 1'b1;
    #1;
    chk("t2_deq_valid", q_if.deq_valid, 1);
    chk("t2_deq_data", q_if.deq_data, A1);
    chk("t2_enq_ready_full", q_if.enq_ready, 2'b00);
    tick();
    idle();
    chk("t2_count", q_if.count, 7);
    chk("t2_entry_valid", q_if.entry_valid, 8'h7F);
    chk("t2_dout1", q_if.entry_douts[1], B0);
    chk("t2_dout2", q_if.entry_douts[2], B1);
    chk("t2_dout3", q_if.entry_douts[3], A2);
    chk("t2_dout6", q_if.entry_douts[6], B3);

    // Drop the youngest to reach count 6: A0,B0,B1,A2,B2,A3.
    q_if.deq_sel_onehot = 8'h40;
    q_if.deq_ready      = 1'b1;
    tick();
    idle();
    chk("prep3_count", q_if.count, 6);

    // 3. Deq entry 1 + flush 4,5 + enq attempt.
    q_if.deq_sel_onehot = 8'h02;
    q_if.deq_ready      = 1'b1;
    q_if.flush_valid    = 1'b1;
    q_if.flush_mask     = 8'h30;
    q_if.enq_valid      = 2'b11;
    q_if.enq_data[0]    = X;
    q_if.enq_data[1]    = Y;
    #1;
    chk("t3_enq_ready", q_if.enq_ready, 2'b00);
    tick();
    idle();
    chk("t3_count", q_if.count, 3);
    chk("t3_entry_valid", q_if.entry_valid, 8'h07);
    chk("t3_dout0", q_if.entry_douts[0], A0);
    chk("t3_dout1", q_if.entry_douts[1], B1);
    chk("t3_dout2", q_if.entry_douts[2], A2);

    // Enqueue two to reach count 5: A0,B1,A2,C0,C1.
    q_if.enq_valid   = 2'b11;
    q_if.enq_data[0] = C0;
    q_if.enq_data[1] = C1;
    tick();
    idle();
    chk("prep4_count", q_if.count, 5);

    // 4. Deq entry 0, write entry 3, enqueue {X,Y}.
    q_if.deq_sel_onehot = 8'h01;
    q_if.deq_ready      = 1'b1;
    q_if.wr_en          = 8'h08;
    q_if.wr_data[3]     = Z;
    q_if.enq_valid      = 2'b11;
    q_if.enq_data[0]    = X;
    q_if.enq_data[1]    = Y;
    #1;
    chk("t4_enq_ready", q_if.enq_ready, 2'b11);
    tick();
    idle();
    chk("t4_count", q_if.count, 6);
    chk("t4_dout0", q_if.entry_douts[0], B1);
    chk("t4_dout1", q_if.entry_douts[1], A2);
    chk("t4_dout2", q_if.entry_douts[2], Z);
    chk("t4_dout3", q_if.entry_douts[3], C1);
    chk("t4_dout4", q_if.entry_douts[4], X);
    chk("t4_dout5", q_if.entry_douts[5], Y);

    // Flush slots 3..5 to reach count 3: B1,A2,Z.
    q_if.flush_valid = 1'b1;
    q_if.flush_mask  = 8'h38;
    tick();
    idle();
    chk("prep5_count", q_if.count, 3);

    // 5. Deq select on an invalid slot, flush mask only on invalid slots.
    q_if.deq_sel_onehot = 8'h20;
    q_if.deq_ready      = 1'b1;
    q_if.flush_valid    = 1'b1;
    q_if.flush_mask     = 8'hF0;
    #1;
    chk("t5_deq_valid", q_if.deq_valid, 0);
    tick();
    idle();
    chk("t5_count", q_if.count, 3);
    chk("t5_dout0", q_if.entry_douts[0], B1);
    chk("t5_dout1", q_if.entry_douts[1], A2);
    chk("t5_dout2", q_if.entry_douts[2], Z);

    // One-lane enqueue to reach count 4.
    q_if.enq_valid   = 2'b01;
    q_if.enq_data[0] = WV;
    tick();
    idle();
    chk("prep6_count", q_if.count, 4);
    chk("prep6_dout3", q_if.entry_douts[3], WV);

    // 6. Reset wins over same-cycle enq and deq.
    rst                 = 1'b1;
    q_if.enq_valid      = 2'b11;
    q_if.enq_data[0]    = X;
    q_if.enq_data[1]    = Y;
    q_if.deq_sel_onehot = 8'h01;
    q_if.deq_ready      = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("t6_count", q_if.count, 0);
    chk("t6_entry_valid", q_if.entry_valid, 0);
    chk("t6_enq_ready", q_if.enq_ready, 2'b11);
    for (int i = 0; i < N; i++) chk($sformatf("t6_dout_%0d", i), q_if.entry_douts[i], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
